// File: rtl/mips_memwb_pkg.sv
// Shared definitions for the MEM/WB pipeline register: FSM encoding,
// register-0 constant, halfword select bit and the WB slot layout.
package mips_memwb_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         HALF_SEL_BIT = 1;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] wb_data;
    logic [31:0] pc;
  } wb_slot_t;

endpackage

// File: rtl/mips_memwb_if.sv
// MEM-stage inputs and WB-stage outputs of the MEM/WB register.
interface mips_memwb_if #(
  parameter int CNT_W = 32
);
  logic             Stall;
  logic             Flush;
  logic             Valid_in;
  logic             RegWrite_in;
  logic             MemToReg_in;
  logic             HalfW_in;
  logic             LoadSigned_in;
  logic             Halt_in;
  logic [4:0]       WriteReg_in;
  logic [31:0]      AluResult;
  logic [31:0]      MemReadData;
  logic [31:0]      PC_in;

  logic             RegWrite;
  logic [4:0]       WriteReg;
  logic [31:0]      WriteBackData;
  logic [31:0]      PC_out;
  logic             Valid_out;
  logic             Halted;
  logic [CNT_W-1:0] RetireCount;

  modport master (
    output Stall, Flush, Valid_in, RegWrite_in, MemToReg_in, HalfW_in,
           LoadSigned_in, Halt_in, WriteReg_in, AluResult, MemReadData, PC_in,
    input  RegWrite, WriteReg, WriteBackData, PC_out, Valid_out, Halted,
           RetireCount
  );

  modport slave (
    input  Stall, Flush, Valid_in, RegWrite_in, MemToReg_in, HalfW_in,
           LoadSigned_in, Halt_in, WriteReg_in, AluResult, MemReadData, PC_in,
    output RegWrite, WriteReg, WriteBackData, PC_out, Valid_out, Halted,
           RetireCount
  );
endinterface

// File: rtl/mips_load_align.sv
// Combinational load alignment: word pass-through or halfword select
// with sign/zero extension.
module mips_load_align (
  input  logic        half_w,
  input  logic        load_signed,
  input  logic        half_sel,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic        [15:0] half;
  logic signed [15:0] half_s;

  always_comb begin
    half      = half_sel ? rdata[31:16] : rdata[15:0];
    half_s    = half;
    load_data = rdata;
    if (half_w) begin
      load_data = load_signed ? 32'(half_s) : {16'h0000, half};
    end
  end

endmodule

// File: rtl/mips_memwb.sv
// MEM/WB pipeline register with flush/stall, sticky halt FSM and a
// retired-instruction counter.
module mips_memwb
  import mips_memwb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        CLK,
  input  logic        RST,
  mips_memwb_if.slave bus
);

  state_e           state_q, state_d;
  wb_slot_t         slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      load_data;

  mips_load_align u_align (
    .half_w      (bus.HalfW_in),
    .load_signed (bus.LoadSigned_in),
    .half_sel    (bus.AluResult[HALF_SEL_BIT]),
    .rdata       (bus.MemReadData),
    .load_data   (load_data)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    if (bus.Flush) begin
      slot_d = '0;
    end else if (!bus.Stall) begin
      if (state_q == ST_HALTED) begin
        slot_d = '0;
      end else begin
        slot_d.valid     = bus.Valid_in;
        slot_d.reg_write = bus.RegWrite_in & bus.Valid_in &
                           (bus.WriteReg_in != REG_ZERO);
        slot_d.write_reg = bus.WriteReg_in;
        slot_d.wb_data   = bus.MemToReg_in ? load_data : bus.AluResult;
        slot_d.pc        = bus.PC_in;
        // The halting instruction itself still retires and counts.
        if (bus.Valid_in) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.Halt_in) state_d = ST_HALTED;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      slot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.RegWrite      = slot_q.reg_write;
  assign bus.WriteReg      = slot_q.write_reg;
  assign bus.WriteBackData = slot_q.wb_data;
  assign bus.PC_out        = slot_q.pc;
  assign bus.Valid_out     = slot_q.valid;
  assign bus.Halted        = (state_q == ST_HALTED);
  assign bus.RetireCount   = cnt_q;

endmodule

// File: tb/tb_mips_memwb.sv
// Scoreboard bench for mips_memwb: a 32-bit-counter instance and a 3-bit
// instance share stimulus so counter wrap is exercised.
module tb_mips_memwb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_memwb_if #(.CNT_W(32)) bus ();
  mips_memwb_if #(.CNT_W(3))  bus3 ();

  assign bus3.Stall         = bus.Stall;
  assign bus3.Flush         = bus.Flush;
  assign bus3.Valid_in      = bus.Valid_in;
  assign bus3.RegWrite_in   = bus.RegWrite_in;
  assign bus3.MemToReg_in   = bus.MemToReg_in;
  assign bus3.HalfW_in      = bus.HalfW_in;
  assign bus3.LoadSigned_in = bus.LoadSigned_in;
  assign bus3.Halt_in       = bus.Halt_in;
  assign bus3.WriteReg_in   = bus.WriteReg_in;
  assign bus3.AluResult     = bus.AluResult;
  assign bus3.MemReadData   = bus.MemReadData;
  assign bus3.PC_in         = bus.PC_in;

  mips_memwb #(.CNT_W(32)) dut  (.CLK(clk), .RST(rst), .bus(bus.slave));
  mips_memwb #(.CNT_W(3))  dut3 (.CLK(clk), .RST(rst), .bus(bus3.slave));

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wbd;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Reference load value from the architectural rule, using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic hw, input logic ls,
                                           input logic [31:0] a, input logic [31:0] d);
    int unsigned h;
    if (!hw) return d;
    h = ((a / 2) % 2 == 1) ? (d / 65536) : (d % 65536);
    if (ls && h >= 32768) return 32'(h) - 32'd65536;
    return 32'(h);
  endfunction

  task automatic bubble_model();
    m.valid = 1'b0; m.rw = 1'b0; m.wr = 5'd0; m.wbd = 32'd0; m.pc = 32'd0;
  endtask

  // Apply inputs at a falling edge, record the expected post-edge state.
  task automatic drive(input logic st, input logic fl, input logic v, input logic rwi,
                       input logic m2r, input logic hw, input logic ls, input logic ht,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] mrd, input logic [31:0] pc);
    bus.Stall = st; bus.Flush = fl; bus.Valid_in = v; bus.RegWrite_in = rwi;
    bus.MemToReg_in = m2r; bus.HalfW_in = hw; bus.LoadSigned_in = ls;
    bus.Halt_in = ht; bus.WriteReg_in = wr; bus.AluResult = alu;
    bus.MemReadData = mrd; bus.PC_in = pc;
    if (fl) bubble_model();
    else if (!st) begin
      if (m.halted) bubble_model();
      else begin
        m.valid = v;
        m.rw    = rwi && v && (wr != 5'd0);
        m.wr    = wr;
        m.wbd   = m2r ? ref_load(hw, ls, alu, mrd) : alu;
        m.pc    = pc;
        if (v) begin
          m.cnt = m.cnt + 32'd1;
          if (ht) m.halted = 1'b1;
        end
      end
    end
    sb.push_back(m);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.Stall = 0; bus.Flush = 0; bus.Valid_in = 0; bus.RegWrite_in = 0;
    bus.MemToReg_in = 0; bus.HalfW_in = 0; bus.LoadSigned_in = 0; bus.Halt_in = 0;
    bus.WriteReg_in = '0; bus.AluResult = '0; bus.MemReadData = '0; bus.PC_in = '0;
  endtask

  // Reset raised between edges; expected zeros are checked right after it rises.
  task automatic do_reset();
    #2;
    m = '{default: '0};
    sb.push_back(m);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rnd(input int n, input int halt_rate);
    for (int i = 0; i < n; i++) begin
      drive(($urandom % 6) == 0, ($urandom % 10) == 0, ($urandom % 4) != 0,
            $urandom % 2 == 1, $urandom % 2 == 1, $urandom % 2 == 1, $urandom % 2 == 1,
            (halt_rate > 0) && (($urandom % halt_rate) == 0),
            5'($urandom % 32), $urandom, $urandom, $urandom);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("Valid_out",     {31'd0, bus.Valid_out},  {31'd0, mon_e.valid});
      chk("RegWrite",      {31'd0, bus.RegWrite},   {31'd0, mon_e.rw});
      chk("WriteReg",      {27'd0, bus.WriteReg},   {27'd0, mon_e.wr});
      chk("WriteBackData", bus.WriteBackData,       mon_e.wbd);
      chk("PC_out",        bus.PC_out,              mon_e.pc);
      chk("Halted",        {31'd0, bus.Halted},     {31'd0, mon_e.halted});
      chk("RetireCount",   bus.RetireCount,         mon_e.cnt);
      chk("RetireCount3",  {29'd0, bus3.RetireCount}, {29'd0, mon_e.cnt[2:0]});
    end
  end

  initial begin
    int waitc;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Halfword loads from the upper half, signed then unsigned.
    drive(0, 0, 1, 1, 1, 1, 1, 0, 5'd5, 32'h0000_0102, 32'h8001_1234, 32'h0000_1000);
    drive(0, 0, 1, 1, 1, 1, 0, 0, 5'd6, 32'h0000_0102, 32'h8001_1234, 32'h0000_1004);
    drive(0, 0, 1, 1, 1, 1, 1, 0, 5'd6, 32'h0000_0100, 32'h8001_9234, 32'h0000_1008);
    // Word load to r0: no register write, still retires.
    drive(0, 0, 1, 1, 1, 0, 0, 0, 5'd0, 32'h0000_0200, 32'hCAFE_BABE, 32'h0000_100C);
    // Stall holds, stall+flush behaves as flush.
    drive(1, 0, 1, 1, 0, 0, 0, 0, 5'd9, 32'h1234_5678, 32'h0, 32'h0000_1010);
    drive(1, 1, 1, 1, 0, 0, 0, 0, 5'd9, 32'h1234_5678, 32'h0, 32'h0000_1014);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 5'd9, 32'h1234_5678, 32'h0, 32'h0000_1018);
    rnd(200, 0);

    // Halt retires, then three valid adds are swallowed.
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 0, 1, 5'd2, 32'h0000_000A, 32'h0, 32'h0000_2000);
    for (int i = 0; i < 3; i++)
      drive(0, 0, 1, 1, 0, 0, 0, 0, 5'd3, 32'h0000_0011 + i, 32'h0, 32'h0000_2004 + 4 * i);
    // Reset while halted, then a fresh instruction retires as the first.
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 0, 0, 5'd4, 32'h0000_0077, 32'h0, 32'h0000_3000);
    rnd(300, 40);
    do_reset();
    rnd(60, 0);

    idle_inputs();
    waitc = 0;
    while (sb.size() != 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_memwb.md
MIPS_MEMWB -- requirements
Module: mips_memwb

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 Stall  in  1  hold all MEM/WB state this cycle.
REQ-005 Flush  in  1  load a bubble this cycle.
REQ-006 Valid_in  in  1  MEM-stage instruction is real, not a bubble.
REQ-007 RegWrite_in  in  1  instruction writes the register file.
REQ-008 MemToReg_in  in  1  writeback source: 1 = load data, 0 = ALU result.
REQ-009 HalfW_in  in  1  load is a halfword.
REQ-010 LoadSigned_in  in  1  halfword load is sign-extended (1) or zero-extended (0).
REQ-011 Halt_in  in  1  instruction is a halt/syscall-exit.
REQ-012 WriteReg_in  in  5  destination register number.
REQ-013 AluResult  in  32  address/ALU result from MEM stage, same bus that feeds MIPS_MEM.
REQ-014 MemReadData  in  32  word read from MIPS_MEM.
REQ-015 PC_in  in  32  instruction PC.
REQ-016 RegWrite  out  1  registered write enable to the register file.
REQ-017 WriteReg  out  5  registered destination register.
REQ-018 WriteBackData  out  32  registered writeback value; also the WB forwarding source.
REQ-019 PC_out  out  32  registered PC of the WB instruction.
REQ-020 Valid_out  out  1  WB slot holds a real instruction.
REQ-021 Halted  out  1  sticky: a halt has retired.
REQ-022 RetireCount  out  CNT_W  number of instructions retired since reset.

Function
REQ-023 Latency SHALL be one cycle: MEM inputs at edge N appear on outputs after edge N.
REQ-024 Load data SHALL be: HalfW_in=0 -> MemReadData; HalfW_in=1 -> half selected by AluResult[1] (0 -> [15:0], 1 -> [31:16]), extended to 32 bits per LoadSigned_in.
REQ-025 Writeback data SHALL be the load data when MemToReg_in=1, else AluResult.
REQ-026 Captured RegWrite SHALL be RegWrite_in AND Valid_in AND NOT Halted; writes to register 0 SHALL be captured with RegWrite=0.
REQ-027 Priority SHALL be Flush > Stall > capture; Flush loads Valid_out=0, RegWrite=0, WriteReg=0, WriteBackData=0, PC_out=0.
REQ-028 Stall without Flush SHALL hold every output and the counter unchanged.
REQ-029 State SHALL be RUN or HALTED; RUN -> HALTED on the edge capturing Valid_in=1, Halt_in=1 (not stalled, not flushed); HALTED exits only by reset.
REQ-030 In HALTED every subsequent capture SHALL be a bubble regardless of inputs; Halted=1 from the edge of transition.
REQ-031 The halting instruction itself SHALL retire (counted, Valid_out=1, its RegWrite honoured).
REQ-032 RetireCount SHALL increment by 1 on each edge capturing a valid non-flushed instruction while in RUN; wraps modulo 2^CNT_W with no flag.
REQ-033 Stall and Flush together SHALL behave as Flush.

Reset
REQ-034 RST SHALL immediately clear all outputs to 0 and state to RUN, including mid-stall or in HALTED.
REQ-035 First capture after RST deassertion SHALL occur on the next rising CLK edge with RST=0.

Structure
REQ-036 Shared package SHALL hold state encoding (RUN, HALTED), register-0 constant, and half-select bit index (1).
REQ-037 Load alignment/extension SHALL be one combinational sub-module, mips_load_align; registers and FSM stay in mips_memwb.

Verification
REQ-038 lh, AluResult=0x102, MemReadData=0x8001_1234, signed -> WriteBackData=0xFFFF8001; unsigned -> 0x00008001.
REQ-039 lw MemToReg=1, WriteReg=0, RegWrite_in=1 -> RegWrite=0, RetireCount still increments.
REQ-040 Valid add captured with Stall=1, Flush=1 -> Valid_out=0, RegWrite=0, counter unchanged.
REQ-041 Halt retired then three valid adds -> Halted=1, RetireCount=1 total, Valid_out=0 after halt slot.
REQ-042 Preload counter near 0xFFFFFFFF (CNT_W=32) and retire two -> wraps to 0x00000000 then 0x00000001.
REQ-043 RST asserted between edges while Halted=1 -> all outputs 0 at once, next valid instruction retires with RetireCount=1.
